// File: rtl/collision_pair_sequencer_if.sv
// Colliding-pair stream from the sequencer FIFO head to the collision-response stage.
interface collision_pair_sequencer_if #(
   parameter int IDX_W = 4
);
   logic             pair_valid;
   logic             pair_ready;
   logic [IDX_W-1:0] pair_a;
   logic [IDX_W-1:0] pair_b;

   modport master (output pair_valid, output pair_a, output pair_b, input pair_ready);
   modport slave  (input pair_valid, input pair_a, input pair_b, output pair_ready);
endinterface

// File: rtl/collision_pair_sequencer.sv
// Narrow-phase sweep over all object pairs (i<j), feeding a combinational detector and queueing hits.
// Optional macro STATIC_SKIP_EN: pairs whose objects both have zero velocity are not evaluated.
module collision_pair_sequencer #(
   parameter  int MAX_OBJS   = 16,
   parameter  int FIFO_DEPTH = 8,
   localparam int IDX_W      = $clog2(MAX_OBJS)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic        [IDX_W:0]      num_objs_i,
   output logic        [IDX_W-1:0]    obj_addr_o,
   input  logic        [207:0]        obj_rdata_i,
   output logic signed [7:0]          widthA_o,
   output logic signed [7:0]          heightA_o,
   output logic signed [31:0]         posA_x_o,
   output logic signed [31:0]         posA_y_o,
   output logic signed [31:0]         velA_x_o,
   output logic signed [31:0]         velA_y_o,
   output logic signed [15:0]         uA_x_o,
   output logic signed [15:0]         uA_y_o,
   output logic signed [15:0]         vA_x_o,
   output logic signed [15:0]         vA_y_o,
   output logic signed [7:0]          widthB_o,
   output logic signed [7:0]          heightB_o,
   output logic signed [31:0]         posB_x_o,
   output logic signed [31:0]         posB_y_o,
   output logic signed [31:0]         velB_x_o,
   output logic signed [31:0]         velB_y_o,
   output logic signed [15:0]         uB_x_o,
   output logic signed [15:0]         uB_y_o,
   output logic signed [15:0]         vB_x_o,
   output logic signed [15:0]         vB_y_o,
   input  logic                       is_collision_i,
   collision_pair_sequencer_if.master pair_if,
   output logic                       busy_o,
   output logic                       done_o,
   output logic        [15:0]         collision_count_o
);

   localparam int REC_W = 208;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W:0]   N_TWO    = (IDX_W+1)'(2);
   localparam logic [IDX_W:0]   N_MAX    = (IDX_W+1)'(MAX_OBJS);
   localparam logic [IDX_W+1:0] EXT_ONE  = (IDX_W+2)'(1);
   localparam logic [IDX_W+1:0] EXT_TWO  = (IDX_W+2)'(2);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_LD_A,
      S_RD_B,
      S_LD_B,
      S_EVAL,
      S_PUSH,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W:0]       n_q, n_d;
   logic [IDX_W-1:0]     i_q, i_d;
   logic [IDX_W-1:0]     j_q, j_d;
   logic [IDX_W-1:0]     addr_q, addr_d;
   logic [REC_W-1:0]     opa_q, opa_d;
   logic [REC_W-1:0]     opb_q, opb_d;
   logic [15:0]          count_q, count_d;

   logic [2*IDX_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     fill_q, fill_d;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic                 advance;
   logic                 more_j;
   logic                 more_i;
   logic [IDX_W:0]       n_req;

   function automatic logic [IDX_W:0] clamp_count(input logic [IDX_W:0] req);
      logic [IDX_W:0] res;
      res = (req > N_MAX) ? N_MAX : req;
      return res;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      logic [15:0] res;
      res = (val == 16'hFFFF) ? val : val + 16'd1;
      return res;
   endfunction

`ifdef STATIC_SKIP_EN
   function automatic logic is_static(input logic [REC_W-1:0] rec);
      return rec[127:64] == 64'd0;
   endfunction
`endif

   assign n_req  = clamp_count(num_objs_i);
   // j+1 < n and i+2 < n, widened so MAX_OBJS itself is representable.
   assign more_j = ({2'b00, j_q} + EXT_ONE) < {1'b0, n_q};
   assign more_i = ({2'b00, i_q} + EXT_TWO) < {1'b0, n_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         addr_q  <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         i_q     <= i_d;
         j_q     <= j_d;
         addr_q  <= addr_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      i_d     = i_q;
      j_d     = j_q;
      addr_d  = addr_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      count_d = count_q;
      push    = 1'b0;
      advance = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               n_d     = n_req;
               i_d     = '0;
               count_d = '0;
               if (n_req < N_TWO) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = '0;
                  state_d = S_RD_A;
               end
            end
         end
         S_RD_A: state_d = S_LD_A;
         S_LD_A: begin
            opa_d   = obj_rdata_i;
            j_d     = i_q + IDX_ONE;
            addr_d  = i_q + IDX_ONE;
            state_d = S_RD_B;
         end
         S_RD_B: state_d = S_LD_B;
         S_LD_B: begin
            opb_d = obj_rdata_i;
`ifdef STATIC_SKIP_EN
            if (is_static(opa_q) && is_static(obj_rdata_i)) begin
               advance = 1'b1;
            end else begin
               state_d = S_EVAL;
            end
`else
            state_d = S_EVAL;
`endif
         end
         S_EVAL: begin
            if (is_collision_i) begin
               state_d = S_PUSH;
            end else begin
               advance = 1'b1;
            end
         end
         S_PUSH: begin
            // A full FIFO parks the FSM here with operands and indices untouched.
            if (!fifo_full) begin
               push    = 1'b1;
               count_d = sat_inc16(count_q);
               advance = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (more_j) begin
            j_d     = j_q + IDX_ONE;
            addr_d  = j_q + IDX_ONE;
            state_d = S_RD_B;
         end else if (more_i) begin
            i_d     = i_q + IDX_ONE;
            addr_d  = i_q + IDX_ONE;
            state_d = S_RD_A;
         end else begin
            state_d = S_DONE;
         end
      end
   end

   // Pair FIFO: a push against a full FIFO waits a cycle even if a pop happens now.
   assign fifo_full          = (fill_q == FULL_LVL);
   assign pair_if.pair_valid = (fill_q != '0);
   assign pop                = pair_if.pair_valid && pair_if.pair_ready;
   assign {pair_if.pair_a, pair_if.pair_b} = fifo_mem[rd_ptr_q];

   always_comb begin
      fill_d = fill_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + CNT_ONE;
         2'b01:   fill_d = fill_q - CNT_ONE;
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         fill_q <= fill_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= {i_q, j_q};
   end

   assign obj_addr_o        = addr_q;
   assign busy_o            = (state_q != S_IDLE);
   assign done_o            = (state_q == S_DONE);
   assign collision_count_o = count_q;

   assign widthA_o  = opa_q[207:200];
   assign heightA_o = opa_q[199:192];
   assign posA_x_o  = opa_q[191:160];
   assign posA_y_o  = opa_q[159:128];
   assign velA_x_o  = opa_q[127:96];
   assign velA_y_o  = opa_q[95:64];
   assign uA_x_o    = opa_q[63:48];
   assign uA_y_o    = opa_q[47:32];
   assign vA_x_o    = opa_q[31:16];
   assign vA_y_o    = opa_q[15:0];

   assign widthB_o  = opb_q[207:200];
   assign heightB_o = opb_q[199:192];
   assign posB_x_o  = opb_q[191:160];
   assign posB_y_o  = opb_q[159:128];
   assign velB_x_o  = opb_q[127:96];
   assign velB_y_o  = opb_q[95:64];
   assign uB_x_o    = opb_q[63:48];
   assign uB_y_o    = opb_q[47:32];
   assign vB_x_o    = opb_q[31:16];
   assign vB_y_o    = opb_q[15:0];

endmodule

// File: tb/tb_collision_pair_sequencer.sv
// Bench for collision_pair_sequencer: table-driven sweeps, corner sequences and randomized sweeps vs a pair-list model.
`timescale 1ns/1ps
module tb_collision_pair_sequencer;

   localparam int MAX_OBJS   = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int IDX_W      = $clog2(MAX_OBJS);

`ifdef STATIC_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              start;
   logic [IDX_W:0]    num_objs;
   logic [IDX_W-1:0]  obj_addr;
   logic [207:0]      obj_rdata;
   logic              is_collision;
   logic              busy, done;
   logic [15:0]       ccount;
   logic signed [7:0]  widthA, heightA, widthB, heightB;
   logic signed [31:0] posA_x, posA_y, velA_x, velA_y, posB_x, posB_y, velB_x, velB_y;
   logic signed [15:0] uA_x, uA_y, vA_x, vA_y, uB_x, uB_y, vB_x, vB_y;

   logic [207:0] mem [MAX_OBJS];

   collision_pair_sequencer_if #(.IDX_W(IDX_W)) pif ();

   collision_pair_sequencer #(.MAX_OBJS(MAX_OBJS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_objs_i(num_objs),
      .obj_addr_o(obj_addr), .obj_rdata_i(obj_rdata),
      .widthA_o(widthA), .heightA_o(heightA), .posA_x_o(posA_x), .posA_y_o(posA_y),
      .velA_x_o(velA_x), .velA_y_o(velA_y), .uA_x_o(uA_x), .uA_y_o(uA_y),
      .vA_x_o(vA_x), .vA_y_o(vA_y),
      .widthB_o(widthB), .heightB_o(heightB), .posB_x_o(posB_x), .posB_y_o(posB_y),
      .velB_x_o(velB_x), .velB_y_o(velB_y), .uB_x_o(uB_x), .uB_y_o(uB_y),
      .vB_x_o(vB_x), .vB_y_o(vB_y),
      .is_collision_i(is_collision), .pair_if(pif.master),
      .busy_o(busy), .done_o(done), .collision_count_o(ccount)
   );

   // Object table with one-cycle read latency.
   always_ff @(posedge clk) obj_rdata <= mem[obj_addr];

   // Stand-in detector: axis-aligned boxes, integer part of Q8.24 positions, width/height extents.
   function automatic bit overlap(input logic [207:0] a, input logic [207:0] b);
      longint ax, ay, bx, by, aw, ah, bw, bh;
      ax = $signed(a[191:160]); ax = ax >>> 24;
      ay = $signed(a[159:128]); ay = ay >>> 24;
      bx = $signed(b[191:160]); bx = bx >>> 24;
      by = $signed(b[159:128]); by = by >>> 24;
      aw = a[207:200]; ah = a[199:192];
      bw = b[207:200]; bh = b[199:192];
      return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
   endfunction

   assign is_collision = overlap({widthA, heightA, posA_x, posA_y, velA_x, velA_y, uA_x, uA_y, vA_x, vA_y},
                                 {widthB, heightB, posB_x, posB_y, velB_x, velB_y, uB_x, uB_y, vB_x, vB_y});

   function automatic logic [207:0] mk(input logic [7:0] w, input logic [7:0] h, input logic [31:0] px,
                                       input logic [31:0] py, input logic [31:0] vx, input logic [31:0] vy);
      return {w, h, px, py, vx, vy, 16'h4000, 16'h0000, 16'h0000, 16'h4000};
   endfunction

   // Observed behaviour, sampled on the falling edge.
   int busy_cycles, done_cnt;
   int got_a[$], got_b[$];
   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (pif.pair_valid && pif.pair_ready) begin
         got_a.push_back(int'(pif.pair_a));
         got_b.push_back(int'(pif.pair_b));
      end
   end

   // Reference: ordered list of colliding pairs and busy length for a sweep over the table.
   int exp_a[$], exp_b[$];
   int exp_busy;

   function automatic bit skip_pair(input int p, input int q);
      return SKIP_EN && (mem[p][127:64] == 64'd0) && (mem[q][127:64] == 64'd0);
   endfunction

   task automatic build_model(input int n_req);
      int n;
      n = (n_req > MAX_OBJS) ? MAX_OBJS : n_req;
      exp_a.delete();
      exp_b.delete();
      exp_busy = 1;
      for (int p = 0; p < n - 1; p++) begin
         exp_busy += 2;
         for (int q = p + 1; q < n; q++) begin
            if (skip_pair(p, q)) begin
               exp_busy += 2;
            end else begin
               exp_busy += 3;
               if (overlap(mem[p], mem[q])) begin
                  exp_busy += 1;
                  exp_a.push_back(p);
                  exp_b.push_back(q);
               end
            end
         end
      end
   endtask

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic load_layout(input int layout);
      logic [31:0] px;
      for (int k = 0; k < MAX_OBJS; k++) begin
         case (layout)
            0:       px = (k == 0) ? 32'h0E00_0000 : (k == 1) ? 32'h1400_0000 :
                          32'h2800_0000 + 32'(k - 2) * 32'h1000_0000;
            1:       px = 32'h0E00_0000 + 32'(k) * 32'h0100_0000;
            default: px = 32'(k) * 32'h1000_0000;
         endcase
         mem[k] = mk(8'd10, 8'd10, px, 32'h0E00_0000, 32'd1, 32'd0);
      end
   endtask

   task automatic start_sweep(input int n);
      busy_cycles = 0;
      done_cnt    = 0;
      got_a.delete();
      got_b.delete();
      @(posedge clk); #1;
      start    = 1'b1;
      num_objs = n[IDX_W:0];
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_done(input bit rand_ready, input int budget);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(posedge clk); #1;
         if (rand_ready) pif.pair_ready = 1'($urandom_range(0, 1));
         k++;
      end
      if (done_cnt == 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
      end
      pif.pair_ready = 1'b1;
      repeat (FIFO_DEPTH + 4) @(posedge clk);
      #1;
   endtask

   task automatic compare_sweep(input string tag, input bit chk_busy);
      check({tag, "_npairs"}, got_a.size(), exp_a.size());
      for (int k = 0; k < got_a.size() && k < exp_a.size(); k++)
         check({tag, "_pair"}, got_a[k] * 16 + got_b[k], exp_a[k] * 16 + exp_b[k]);
      check({tag, "_count"}, ccount, exp_a.size());
      check({tag, "_done"}, done_cnt, 1);
      if (chk_busy) check({tag, "_busy"}, busy_cycles, exp_busy);
   endtask

   typedef struct {
      int n;
      int layout;
      int exp_count;
      int exp_busy;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      logic [IDX_W-1:0] addr_before;
      int n;
      bit rmode;

      vecs[0] = '{n: 3,  layout: 0, exp_count: 1, exp_busy: 15};
      vecs[1] = '{n: 1,  layout: 1, exp_count: 0, exp_busy: 1};
      vecs[2] = '{n: 0,  layout: 1, exp_count: 0, exp_busy: 1};
      vecs[3] = '{n: 4,  layout: 1, exp_count: 6, exp_busy: 31};
      vecs[4] = '{n: 12, layout: 2, exp_count: 0, exp_busy: 99};

      rst_n          = 1'b0;
      start          = 1'b0;
      num_objs       = '0;
      pif.pair_ready = 1'b1;
      load_layout(2);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      check("rst_busy", busy, 0);
      check("rst_valid", pif.pair_valid, 0);
      check("rst_count", ccount, 0);
      check("rst_done", done, 0);
      check("rst_addr", obj_addr, 0);
      check("rst_opA", posA_x, 0);
      check("rst_opB", widthB, 0);
      busy_cycles = 0;
      done_cnt    = 0;
      repeat (20) @(posedge clk);
      #1;
      check("idle_busy", busy_cycles, 0);
      check("idle_done", done_cnt, 0);

      // Table-driven sweeps with the consumer always ready.
      for (int v = 0; v < 5; v++) begin
         load_layout(vecs[v].layout);
         build_model(vecs[v].n);
         addr_before = obj_addr;
         start_sweep(vecs[v].n);
         wait_done(1'b0, 500);
         check("vec_count", ccount, vecs[v].exp_count);
         check("vec_busy", busy_cycles, vecs[v].exp_busy);
         compare_sweep("vec", 1'b1);
         if (vecs[v].n < 2) check("vec_addr_hold", obj_addr, addr_before);
      end

      // Backpressure: depth-2 FIFO fills, third hit stalls in PUSH on pair (0,3).
      load_layout(1);
      build_model(4);
      pif.pair_ready = 1'b0;
      start_sweep(4);
      repeat (60) @(posedge clk);
      #1;
      check("bp_busy", busy, 1);
      check("bp_done", done_cnt, 0);
      check("bp_count", ccount, 2);
      check("bp_valid", pif.pair_valid, 1);
      check("bp_head", pif.pair_a * 16 + pif.pair_b, 1);
      check("bp_addr", obj_addr, 3);
      check("bp_opB", posB_x, 32'h1100_0000);
      check("bp_nopop", got_a.size(), 0);
      pif.pair_ready = 1'b1;
      wait_done(1'b0, 500);
      compare_sweep("bp", 1'b0);

      // Asynchronous reset during the second pair of a 4-object sweep.
      load_layout(1);
      pif.pair_ready = 1'b0;
      start_sweep(4);
      repeat (7) @(posedge clk);
      check("ar_pre_valid", pif.pair_valid, 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("ar_busy", busy, 0);
      check("ar_valid", pif.pair_valid, 0);
      check("ar_count", ccount, 0);
      check("ar_addr", obj_addr, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("ar_nodone", done_cnt, 0);
      pif.pair_ready = 1'b1;
      build_model(4);
      start_sweep(4);
      wait_done(1'b0, 500);
      compare_sweep("ar_rerun", 1'b1);

      // Randomized tables, counts (including over-range) and consumer readiness.
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < MAX_OBJS; k++) begin
            mem[k] = mk(8'($urandom_range(1, 20)), 8'($urandom_range(1, 20)),
                        32'($urandom_range(0, 60)) << 24, 32'($urandom_range(0, 30)) << 24,
                        ($urandom_range(0, 2) == 0) ? 32'd0 : 32'd1,
                        ($urandom_range(0, 2) == 0) ? 32'd0 : 32'hFFFF_FFFF);
         end
         n     = int'($urandom_range(0, MAX_OBJS + 3));
         rmode = it[0];
         pif.pair_ready = 1'b1;
         build_model(n);
         start_sweep(n);
         wait_done(rmode, 3000);
         compare_sweep("rnd", !rmode);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
